// File: rtl/controlador_ascensor.sv
// controlador_ascensor: SCAN elevator car controller.
// Reads the merged pending-request vector from the request registrador and
// drives the motor and door lines.
// The car keeps its travel direction while requests remain ahead of it.
// Ports:
//   SystemClock    - clock, all state changes on its rising edge
//   reset_n        - asynchronous active-low reset
//   solicitudes    - pending requests, bit i = floor i
//   atendido       - one-hot, one-cycle clear strobe for the floor just served
//   piso_actual    - current floor
//   motor_subir    - drive car up
//   motor_bajar    - drive car down
//   puerta_abierta - door open
//   direccion      - retained travel direction (1 = up)
module controlador_ascensor #(
  parameter int N_PISOS  = 4,
  parameter int T_VIAJE  = 4,
  parameter int T_PUERTA = 3
) (
  input  logic                       SystemClock,
  input  logic                       reset_n,
  input  logic [N_PISOS-1:0]         solicitudes,
  output logic [N_PISOS-1:0]         atendido,
  output logic [$clog2(N_PISOS)-1:0] piso_actual,
  output logic                       motor_subir,
  output logic                       motor_bajar,
  output logic                       puerta_abierta,
  output logic                       direccion
);
  localparam int PW = $clog2(N_PISOS);
  localparam int TW = (T_VIAJE  > 1) ? $clog2(T_VIAJE)  : 1;
  localparam int DW = (T_PUERTA > 1) ? $clog2(T_PUERTA) : 1;
  localparam logic [PW-1:0] PISO_TOP   = PW'(N_PISOS - 1);
  localparam logic [TW-1:0] VIAJE_FIN  = TW'(T_VIAJE - 1);
  localparam logic [DW-1:0] PUERTA_FIN = DW'(T_PUERTA - 1);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} estado_t;

  estado_t           estado, estado_nx;
  logic [TW-1:0]     cnt_viaje, cnt_viaje_nx;
  logic [DW-1:0]     cnt_puerta, cnt_puerta_nx;
  logic [PW-1:0]     piso_nx, p_dec;
  logic [N_PISOS-1:0] atendido_nx, m;
  logic              subir_nx, bajar_nx, puerta_nx, dir_nx, dir_f;
  logic              arribo, aqui, arriba, abajo, adelante, atras, decidir;

  // The registrador clears a served bit one cycle late; masking with the
  // strobe still on the outputs hides that stale bit for exactly that cycle.
  assign m = solicitudes & ~atendido;

  // Decision floor: the floor being reached on this edge while moving,
  // otherwise the current floor.
  assign arribo = (estado == MOVING) && (cnt_viaje == VIAJE_FIN);
  assign p_dec  = !arribo   ? piso_actual :
                  direccion ? piso_actual + PW'(1) : piso_actual - PW'(1);

  // Direction is pinned at the end floors before deciding.
  always_comb begin
    dir_f = direccion;
    if (p_dec == PISO_TOP)   dir_f = 1'b0;
    else if (p_dec == '0)    dir_f = 1'b1;
  end

  always_comb begin
    aqui   = 1'b0;
    arriba = 1'b0;
    abajo  = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (PW'(i) == p_dec)     aqui   = m[i];
      else if (PW'(i) > p_dec) arriba = arriba | m[i];
      else                     abajo  = abajo  | m[i];
    end
  end

  assign adelante = dir_f ? arriba : abajo;
  assign atras    = dir_f ? abajo  : arriba;

  always_comb begin
    estado_nx     = estado;
    cnt_viaje_nx  = cnt_viaje;
    cnt_puerta_nx = cnt_puerta;
    piso_nx       = piso_actual;
    dir_nx        = direccion;
    atendido_nx   = '0;
    subir_nx      = 1'b0;
    bajar_nx      = 1'b0;
    puerta_nx     = 1'b0;
    decidir       = 1'b0;
    case (estado)
      IDLE: decidir = 1'b1;
      MOVING: begin
        if (arribo) begin
          piso_nx      = p_dec;
          cnt_viaje_nx = '0;
          decidir      = 1'b1;
        end else begin
          cnt_viaje_nx = cnt_viaje + TW'(1);
          subir_nx     = motor_subir;
          bajar_nx     = motor_bajar;
        end
      end
      DOOR_OPEN: begin
        puerta_nx = 1'b1;
        if (aqui) begin
          // re-request while open: serve again and restart the dwell
          atendido_nx   = N_PISOS'(1) << piso_actual;
          cnt_puerta_nx = '0;
        end else if (cnt_puerta == PUERTA_FIN) begin
          estado_nx     = IDLE;
          puerta_nx     = 1'b0;
          cnt_puerta_nx = '0;
        end else begin
          cnt_puerta_nx = cnt_puerta + DW'(1);
        end
      end
      default: estado_nx = IDLE;
    endcase

    if (decidir) begin
      dir_nx = dir_f;
      if (aqui) begin
        estado_nx     = DOOR_OPEN;
        puerta_nx     = 1'b1;
        atendido_nx   = N_PISOS'(1) << p_dec;
        cnt_puerta_nx = '0;
      end else if (adelante) begin
        estado_nx    = MOVING;
        subir_nx     = dir_f;
        bajar_nx     = !dir_f;
        cnt_viaje_nx = '0;
      end else if (atras) begin
        estado_nx    = MOVING;
        dir_nx       = !dir_f;
        subir_nx     = !dir_f;
        bajar_nx     = dir_f;
        cnt_viaje_nx = '0;
      end else begin
        estado_nx = IDLE;
      end
    end
  end

  always_ff @(posedge SystemClock or negedge reset_n) begin
    if (!reset_n) begin
      estado         <= IDLE;
      cnt_viaje      <= '0;
      cnt_puerta     <= '0;
      piso_actual    <= '0;
      direccion      <= 1'b1;
      atendido       <= '0;
      motor_subir    <= 1'b0;
      motor_bajar    <= 1'b0;
      puerta_abierta <= 1'b0;
    end else begin
      estado         <= estado_nx;
      cnt_viaje      <= cnt_viaje_nx;
      cnt_puerta     <= cnt_puerta_nx;
      piso_actual    <= piso_nx;
      direccion      <= dir_nx;
      atendido       <= atendido_nx;
      motor_subir    <= subir_nx;
      motor_bajar    <= bajar_nx;
      puerta_abierta <= puerta_nx;
    end
  end
endmodule

// File: tb/tb_controlador_ascensor.sv
// Bench for controlador_ascensor: directed scenarios followed by random
// request traffic, every cycle compared against an event-level car model.
// The bench also plays the registrador, clearing a served bit one cycle
// after the atendido strobe.
module tb_controlador_ascensor;
  localparam int N  = 4;
  localparam int TV = 4;
  localparam int TP = 3;

  logic         SystemClock = 1'b0;
  logic         reset_n     = 1'b0;
  logic [N-1:0] solicitudes = '0;
  logic [N-1:0] atendido;
  logic [1:0]   piso_actual;
  logic         motor_subir, motor_bajar, puerta_abierta, direccion;

  controlador_ascensor #(.N_PISOS(N), .T_VIAJE(TV), .T_PUERTA(TP)) dut (
    .SystemClock   (SystemClock),
    .reset_n       (reset_n),
    .solicitudes   (solicitudes),
    .atendido      (atendido),
    .piso_actual   (piso_actual),
    .motor_subir   (motor_subir),
    .motor_bajar   (motor_bajar),
    .puerta_abierta(puerta_abierta),
    .direccion     (direccion)
  );

  always #5 SystemClock = ~SystemClock;

  int checks = 0, errors = 0;
  int pend_clr = -1;
  int n_sub = 0, n_baj = 0, n_door = 0;

  // Car model: floor, direction, remaining door cycles, whether travelling,
  // ticks travelled toward the next floor, floor strobed last edge (-1 none).
  int m_piso, m_door, m_prog, m_pulse;
  bit m_dir, m_mov;

  task automatic model_reset();
    m_piso = 0; m_dir = 1; m_door = 0; m_mov = 0; m_prog = 0; m_pulse = -1;
  endtask

  function automatic bit hay(input logic [N-1:0] r, input int desde, input bit hacia_arriba);
    for (int i = 0; i < N; i++)
      if ((hacia_arriba ? (i > desde) : (i < desde)) && r[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic [N-1:0] s);
    logic [N-1:0] r;
    int pulse_nx;
    bit dec;
    r = s;
    pulse_nx = -1;
    dec = 1'b1;
    if (m_pulse >= 0) r[m_pulse] = 1'b0;
    if (m_door > 0) begin
      if (r[m_piso]) begin pulse_nx = m_piso; m_door = TP; end
      else m_door = m_door - 1;
    end else begin
      if (m_mov) begin
        m_prog = m_prog + 1;
        if (m_prog == TV) begin
          m_piso = m_dir ? m_piso + 1 : m_piso - 1;
          m_prog = 0;
        end else dec = 1'b0;
      end
      if (dec) begin
        if (m_piso == N-1) m_dir = 1'b0;
        if (m_piso == 0)   m_dir = 1'b1;
        if (r[m_piso]) begin
          m_mov = 1'b0; m_door = TP; pulse_nx = m_piso;
        end else if (hay(r, m_piso, m_dir)) begin
          m_mov = 1'b1; m_prog = 0;
        end else if (hay(r, m_piso, !m_dir)) begin
          m_dir = !m_dir; m_mov = 1'b1; m_prog = 0;
        end else m_mov = 1'b0;
      end
    end
    m_pulse = pulse_nx;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic comparar();
    logic [N-1:0] at_exp;
    at_exp = (m_pulse >= 0) ? (N'(1) << m_pulse) : '0;
    chk("piso",     32'(piso_actual),    32'(m_piso));
    chk("dir",      32'(direccion),      32'(m_dir));
    chk("atendido", 32'(atendido),       32'(at_exp));
    chk("subir",    32'(motor_subir),    32'(m_mov && m_dir));
    chk("bajar",    32'(motor_bajar),    32'(m_mov && !m_dir));
    chk("puerta",   32'(puerta_abierta), 32'(m_door > 0));
    chk("inv_motores",      32'(motor_subir & motor_bajar), 32'(0));
    chk("inv_puerta_motor", 32'(puerta_abierta & (motor_subir | motor_bajar)), 32'(0));
    chk("inv_onehot",       32'($onehot0(atendido)), 32'(1));
  endtask

  task automatic ciclo();
    @(posedge SystemClock);
    model_step(solicitudes);
    @(negedge SystemClock);
    comparar();
    n_sub  += 32'(motor_subir);
    n_baj  += 32'(motor_bajar);
    n_door += 32'(puerta_abierta);
    if (pend_clr >= 0) solicitudes[pend_clr] = 1'b0;
    pend_clr = m_pulse;
  endtask

  task automatic esperar_pulso(input string tag, input int budget);
    int k;
    k = 0;
    do begin ciclo(); k++; end while (atendido == '0 && k < budget);
    chk(tag, 32'(atendido != '0), 32'(1));
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge SystemClock);
    chk("rst_piso",     32'(piso_actual),    32'(0));
    chk("rst_dir",      32'(direccion),      32'(1));
    chk("rst_atendido", 32'(atendido),       32'(0));
    chk("rst_motor",    32'({motor_subir, motor_bajar}), 32'(0));
    chk("rst_puerta",   32'(puerta_abierta), 32'(0));
    reset_n = 1'b1;

    // idle with no requests
    n_sub = 0; n_baj = 0; n_door = 0;
    repeat (20) ciclo();
    chk("idle_motor", 32'(n_sub + n_baj), 32'(0));
    chk("idle_door",  32'(n_door),        32'(0));

    // same-floor request at floor 0; stale bit held during the strobe cycle
    solicitudes = 4'b0001;
    ciclo();
    chk("mismo_piso_at",     32'(atendido),       32'(4'b0001));
    chk("mismo_piso_puerta", 32'(puerta_abierta), 32'(1));
    chk("mismo_piso_motor",  32'({motor_subir, motor_bajar}), 32'(0));
    repeat (5) ciclo();

    // floor 0 -> 2
    solicitudes = solicitudes | 4'b0100;
    n_sub = 0; n_door = 0;
    esperar_pulso("to_0_2", 40);
    chk("viaje2_subir", 32'(n_sub),       32'(8));
    chk("viaje2_piso",  32'(piso_actual), 32'(2));
    chk("viaje2_at",    32'(atendido),    32'(4'b0100));
    repeat (5) ciclo();
    chk("viaje2_door",  32'(n_door),      32'(3));

    // go to floor 1, then sweep up to 3 and back down to 0
    solicitudes = solicitudes | 4'b0010;
    esperar_pulso("to_piso1", 40);
    repeat (5) ciclo();
    solicitudes = solicitudes | 4'b1000;
    repeat (2) ciclo();
    chk("scan_subiendo", 32'(motor_subir), 32'(1));
    solicitudes = solicitudes | 4'b0001;
    esperar_pulso("to_piso3", 40);
    chk("scan_at3", 32'(atendido), 32'(4'b1000));
    n_baj = 0;
    ciclo();
    chk("scan_dir0", 32'(direccion), 32'(0));
    esperar_pulso("to_piso0", 60);
    chk("scan_at0",    32'(atendido), 32'(4'b0001));
    chk("scan_bajar",  32'(n_baj),    32'(12));
    repeat (5) ciclo();

    // asynchronous reset in the middle of a move up
    solicitudes = solicitudes | 4'b1000;
    repeat (6) ciclo();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_subir", 32'(motor_subir),    32'(0));
    chk("rst_mid_piso",  32'(piso_actual),    32'(0));
    chk("rst_mid_dir",   32'(direccion),      32'(1));
    chk("rst_mid_puerta",32'(puerta_abierta), 32'(0));
    model_reset();
    pend_clr = -1;
    repeat (2) @(posedge SystemClock);
    @(negedge SystemClock);
    reset_n = 1'b1;
    n_sub = 0;
    esperar_pulso("post_rst", 40);
    chk("post_rst_piso",  32'(piso_actual), 32'(3));
    chk("post_rst_subir", 32'(n_sub),       32'(12));
    repeat (5) ciclo();

    // re-request at floor 2 during the door's second cycle
    solicitudes = solicitudes | 4'b0100;
    n_door = 0;
    esperar_pulso("to_piso2", 40);
    chk("rereq_piso", 32'(piso_actual), 32'(2));
    ciclo();
    solicitudes = solicitudes | 4'b0100;
    ciclo();
    chk("rereq_at", 32'(atendido), 32'(4'b0100));
    repeat (6) ciclo();
    chk("rereq_door", 32'(n_door), 32'(5));

    // random traffic
    repeat (1500) begin
      if ($urandom_range(0, 5) == 0) solicitudes[$urandom_range(0, N-1)] = 1'b1;
      ciclo();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/controlador_ascensor.md
# controlador_ascensor

Elevator motion controller that sits directly downstream of the request registrador. It consumes the registrador's merged pending-request vector (`solicitudes`), runs a direction-retaining (SCAN) car-control state machine with floor-travel and door-dwell timers, and drives motor and door outputs. It returns a one-cycle `atendido` pulse so the registrador clears the served request.

## Interface
- `N_PISOS`, 4: number of floors; one request bit per floor, minimum 2.
- `T_VIAJE`, 4: clock cycles of motor activity per one-floor move, minimum 1.
- `T_PUERTA`, 3: clock cycles the door stays open per service, minimum 1.
- `SystemClock`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `solicitudes`  in  N_PISOS  pending requests from the registrador; bit i means floor i is requested.
- `atendido`  out  N_PISOS  one-hot, one-cycle pulse marking the floor just served. It is the registrador clear strobe.
- `piso_actual`  out  $clog2(N_PISOS)  current floor.
- `motor_subir`  out  1  drive car up.
- `motor_bajar`  out  1  drive car down.
- `puerta_abierta`  out  1  door open.
- `direccion`  out  1  retained travel direction: 1 = up, 0 = down.

## Operation
- All outputs are registered.
- Reset values:
  - `piso_actual`=0, `direccion`=1, `atendido`=0, `motor_subir`=0, `motor_bajar`=0, `puerta_abierta`=0.
  - State IDLE; travel and door counters at 0.
- States: IDLE, MOVING, DOOR_OPEN.
- Decision rule, used in IDLE and on every floor arrival. Let p be the floor; "ahead" means floors above p when `direccion`=1, below p otherwise. Priority:
  1. `solicitudes[p]` set: go to DOOR_OPEN.
  2. Any request ahead: go to MOVING, keeping `direccion`.
  3. Any request behind: flip `direccion`, go to MOVING.
  4. Otherwise: go to, or stay in, IDLE.
- MOVING:
  - The motor line matching `direccion` is high.
  - The travel counter runs 0..T_VIAJE-1.
  - At the terminal count, `piso_actual` moves ±1 and the counter returns to 0.
  - The decision rule is then applied to the new floor on that same edge.
  - The car never stops between floors. Requests dropped mid-travel only take effect at the next arrival.
- DOOR_OPEN:
  - On entry: `puerta_abierta`=1, both motor lines 0, and `atendido`=(1<<p) for exactly the entry cycle.
  - The door counter runs T_PUERTA cycles, then the block goes to IDLE and the door closes.
- Registrador clear latency: the cycle immediately after an `atendido` pulse ignores `solicitudes[p]`.
- Re-request while the door is open: if `solicitudes[p]` is set in any later DOOR_OPEN cycle, `atendido` pulses again and the door counter restarts.
- Floor limits:
  - At floor N_PISOS-1, `direccion` is forced to 0 before the decision; at floor 0 it is forced to 1.
  - `piso_actual` never wraps.
- Invariants:
  - `motor_subir` and `motor_bajar` are never high together.
  - No motor line is high while `puerta_abierta`=1.
  - `atendido` has at most one bit set.

## Timing
- Travel latency:
  - From IDLE, a request at floor k≠p first seen on edge n gives motor high from n+1.
  - The motor is high for exactly |k−p|·T_VIAJE cycles.
  - `puerta_abierta` and `atendido` assert on the same edge on which `piso_actual` becomes k.
- Same-floor request in IDLE: door opens on the next edge, with no motor activity.
- Door dwell: `puerta_abierta` is high for T_PUERTA cycles, after which the block spends at least one cycle in IDLE before moving.
- Reset mid-operation:
  - `reset_n` low forces every output to its reset value asynchronously, with no clock needed.
  - A partially travelled floor is discarded.
  - Operation resumes on the first rising edge after `reset_n` goes high.

## Test plan
All scenarios use N_PISOS=4, T_VIAJE=4, T_PUERTA=3.
1. Reset, then idle with `solicitudes`=0000 for 20 cycles -> all outputs 0, `piso_actual`=0, `direccion`=1, no motor activity.
2. At floor 0, set `solicitudes`=0100 -> `motor_subir` high for 8 cycles; `piso_actual` becomes 1 after 4 cycles and 2 after 8; then `puerta_abierta` high for 3 cycles with `atendido`=0100 for one cycle. The bench clears bit 2 after the pulse.
3. At floor 0, set `solicitudes`=0001 -> door opens next cycle, `atendido`=0001, motors stay 0.
4. Moving up from floor 1 toward floor 3, with `solicitudes`=1001 -> floor 3 served first (`atendido`=1000), then `direccion`=0, then floor 0 served after 12 cycles of `motor_bajar`.
5. Pull `reset_n` low in the middle of a move up -> `motor_subir`=0 with no clock edge and `piso_actual`=0. After release, a pending request restarts travel from floor 0.
6. While the door is open at floor 2, reassert bit 2 in the door's second cycle -> second `atendido`=0100 pulse, door stays open 3 more cycles.
